// File: rtl/hamming_serial_tx.sv
// Hamming(7,4) encoder feeding a FIFO and a four-lane serializer that sends codeword bit 1 first.
// Defining ERR_INJECT_EN adds an err_mask input that is XORed into each codeword when it is popped.
module hamming_serial_tx #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:5]             in_data,
`ifdef ERR_INJECT_EN
  input  logic [1:7]             err_mask,
`endif
  output logic [0:3]             tx_line,
  output logic [0:3]             tx_frame,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;
  typedef struct packed {
    logic [1:0] dest;
    logic [1:7] cw;
  } entry_t;

  logic [1:4]    w_d;
  entry_t        w_in, w_head;
  logic [1:7]    w_load_cw;
  logic          w_push, w_pop, w_full, w_empty, w_last_bit, w_gap_done;
  state_t        r_state, w_state_nxt;
  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [1:7]    r_sr;
  logic [2:0]    r_idx;
  logic [1:0]    r_dest;
  logic [GW-1:0] r_gap_cnt;
  logic [0:3]    w_line_nxt, w_frame_nxt, r_tx_line, r_tx_frame;

  assign w_d      = in_data[2:5];
  assign w_in.dest = in_data[0:1];
  assign w_in.cw  = {w_d[1] ^ w_d[2] ^ w_d[4], w_d[1] ^ w_d[3] ^ w_d[4], w_d[1],
                     w_d[2] ^ w_d[3] ^ w_d[4], w_d[2], w_d[3], w_d[4]};

  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = ~rst & ~w_full;
  assign w_push   = in_valid & in_ready;
  assign w_head   = r_mem[r_rd_ptr];

`ifdef ERR_INJECT_EN
  assign w_load_cw = w_head.cw ^ err_mask;
`else
  assign w_load_cw = w_head.cw;
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_last_bit = (r_idx == 3'd7);
  assign w_gap_done = (r_gap_cnt == GAP_LAST);

  // The last bit (no gap) or last gap cycle acts as IDLE, so a queued frame starts with no extra dead cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: if (w_last_bit) begin
        if (GAP_CYCLES > 0) w_state_nxt = S_GAP;
        else if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SHIFT;
        end else w_state_nxt = S_IDLE;
      end
      S_GAP: if (w_gap_done) begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SHIFT;
        end else w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr      <= '0;
      r_idx     <= '0;
      r_dest    <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_sr   <= w_load_cw;
        r_dest <= w_head.dest;
        r_idx  <= 3'd1;
      end else if (r_state == S_SHIFT) begin
        r_sr  <= {r_sr[2:7], 1'b0};
        r_idx <= r_idx + 3'd1;
      end
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_line_nxt  = '0;
    w_frame_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_state == S_SHIFT && r_dest == 2'(i)) begin
        w_frame_nxt[i] = 1'b1;
        w_line_nxt[i]  = r_sr[1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_line  <= '0;
      r_tx_frame <= '0;
    end else begin
      r_tx_line  <= w_line_nxt;
      r_tx_frame <= w_frame_nxt;
    end
  end

  assign tx_line    = r_tx_line;
  assign tx_frame   = r_tx_frame;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_hamming_serial_tx.sv
// Directed bench for hamming_serial_tx: one instance with a 1-cycle gap, one with back-to-back frames.
module tb_hamming_serial_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_valid0 = 1'b0;
  logic [0:5] in_data = '0, in_data0 = '0;
  logic       in_ready, in_ready0, busy, busy0;
  logic [0:3] tx_line, tx_frame, tx_line0, tx_frame0;
  logic [2:0] fifo_count, fifo_count0;
`ifdef ERR_INJECT_EN
  logic [1:7] err_mask = '0;
`endif
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  hamming_serial_tx #(.DEPTH(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef ERR_INJECT_EN
    .err_mask(err_mask),
`endif
    .tx_line(tx_line), .tx_frame(tx_frame), .fifo_count(fifo_count), .busy(busy));

  hamming_serial_tx #(.DEPTH(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
`ifdef ERR_INJECT_EN
    .err_mask(err_mask),
`endif
    .tx_line(tx_line0), .tx_frame(tx_frame0), .fifo_count(fifo_count0), .busy(busy0));

  // Called at a falling edge; the word is taken at the next rising edge.
  task automatic push(input bit g0, input logic [0:5] d);
    if (g0) begin in_valid0 = 1'b1; in_data0 = d; end
    else    begin in_valid  = 1'b1; in_data  = d; end
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid0 = 1'b0;
  endtask

  // Waits (bounded) for a frame, then records its lane and 7 bits; ok=0 on timeout or lane misbehaviour.
  task automatic capture(input bit g0, input int max_wait, output int waited,
                         output logic [1:0] lane, output logic [1:7] cw, output bit ok);
    logic [0:3] fr, ln, ref_fr;
    waited = 0; lane = '0; cw = '0; ok = 1'b0;
    fr = g0 ? tx_frame0 : tx_frame;
    while (fr == 4'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
      fr = g0 ? tx_frame0 : tx_frame;
    end
    if ($countones(fr) != 1) return;
    ref_fr = fr;
    for (int i = 0; i < 4; i++) if (fr[i]) lane = 2'(i);
    ok = 1'b1;
    for (int b = 1; b <= 7; b++) begin
      fr = g0 ? tx_frame0 : tx_frame;
      ln = g0 ? tx_line0  : tx_line;
      if (fr !== ref_fr || (ln & ~ref_fr) != 4'b0) ok = 1'b0;
      cw[b] = ln[lane];
      if (b < 7) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_chk++; if ({tx_line, tx_frame, fifo_count, busy} !== 12'b0)
      $display("FAIL rst_outputs: got %h want 000", {tx_line, tx_frame, fifo_count, busy}); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int w; logic [1:0] ln; logic [1:7] cw; bit ok;
    push(0, {2'd0, 4'b1011});
    n_chk++; if (fifo_count !== 3'd1) $display("FAIL basic_count: got %0d want 1", fifo_count); else n_pass++;
    capture(0, 10, w, ln, cw, ok);
    n_chk++; if (w !== 2) $display("FAIL basic_latency: got %0d want 2", w); else n_pass++;
    n_chk++; if ({ok, ln, cw} !== {1'b1, 2'd0, 7'b0110011})
      $display("FAIL basic_frame: got ok=%b lane=%0d cw=%b want ok=1 lane=0 cw=0110011", ok, ln, cw); else n_pass++;
    @(negedge clk);
    n_chk++; if ({tx_frame, busy} !== 5'b0)
      $display("FAIL basic_end: got frame=%b busy=%b want 0000/0", tx_frame, busy); else n_pass++;
  endtask

  task automatic test_gap();
    int w; logic [1:0] ln; logic [1:7] cw; bit ok;
    push(0, {2'd3, 4'b1111});
    push(0, {2'd2, 4'b0000});
    capture(0, 10, w, ln, cw, ok);
    n_chk++; if ({ok, ln, cw} !== {1'b1, 2'd3, 7'b1111111})
      $display("FAIL gap_frame1: got ok=%b lane=%0d cw=%b want ok=1 lane=3 cw=1111111", ok, ln, cw); else n_pass++;
    @(negedge clk);
    capture(0, 10, w, ln, cw, ok);
    n_chk++; if (w !== 1) $display("FAIL gap_idle_cycles: got %0d want 1", w); else n_pass++;
    n_chk++; if ({ok, ln, cw} !== {1'b1, 2'd2, 7'b0000000})
      $display("FAIL gap_frame2: got ok=%b lane=%0d cw=%b want ok=1 lane=2 cw=0000000", ok, ln, cw); else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [0:5] words [6];
    logic [9:0] exp   [6];
    logic [9:0] got   [6];
    int k, cyc; bit saw_full, bad_full;
    words = '{{2'd1, 4'b0001}, {2'd2, 4'b0010}, {2'd3, 4'b0100},
              {2'd0, 4'b1000}, {2'd1, 4'b1011}, {2'd2, 4'b0110}};
    exp   = '{{1'b1, 2'd1, 7'b1101001}, {1'b1, 2'd2, 7'b0101010}, {1'b1, 2'd3, 7'b1001100},
              {1'b1, 2'd0, 7'b1110000}, {1'b1, 2'd1, 7'b0110011}, {1'b1, 2'd2, 7'b1100110}};
    k = 0; cyc = 0; saw_full = 0; bad_full = 0;
    fork
      begin
        bit acc;
        while (k < 6 && cyc < 100) begin
          in_valid = 1'b1;
          in_data  = words[k];
          if (fifo_count === 3'd4 && in_ready !== 1'b0) bad_full = 1'b1;
          if (fifo_count === 3'd4 && in_ready === 1'b0) saw_full = 1'b1;
          acc = in_ready;
          @(negedge clk);
          if (acc) k++;
          cyc++;
        end
        in_valid = 1'b0;
      end
      begin
        int w; logic [1:0] ln; logic [1:7] cw; bit ok;
        for (int f = 0; f < 6; f++) begin
          if (f > 0) @(negedge clk);
          capture(0, 20, w, ln, cw, ok);
          got[f] = {ok, ln, cw};
        end
      end
    join
    n_chk++; if (k !== 6) $display("FAIL bp_accepted: got %0d want 6", k); else n_pass++;
    n_chk++; if ({saw_full, bad_full} !== 2'b10)
      $display("FAIL bp_ready_at_full: got saw=%b bad=%b want 1/0", saw_full, bad_full); else n_pass++;
    for (int f = 0; f < 6; f++) begin
      n_chk++; if (got[f] !== exp[f])
        $display("FAIL bp_frame%0d: got %b want %b", f, got[f], exp[f]); else n_pass++;
    end
    repeat (3) @(negedge clk);
    n_chk++; if ({fifo_count, busy} !== 4'b0)
      $display("FAIL bp_drained: got count=%0d busy=%b want 0/0", fifo_count, busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w; logic [1:0] ln; logic [1:7] cw; bit ok; bit stray;
    push(0, {2'd3, 4'b1111});
    push(0, {2'd0, 4'b0001});
    push(0, {2'd1, 4'b0010});
    repeat (3) @(negedge clk);
    n_chk++; if ({fifo_count, tx_frame, tx_line} !== {3'd2, 4'b0001, 4'b0001})
      $display("FAIL mid_pre: got count=%0d frame=%b line=%b want 2/0001/0001", fifo_count, tx_frame, tx_line); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if ({tx_line, tx_frame, fifo_count, busy, in_ready} !== 13'b0)
      $display("FAIL mid_rst: got line=%b frame=%b count=%0d busy=%b rdy=%b want all 0",
               tx_line, tx_frame, fifo_count, busy, in_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    push(0, {2'd2, 4'b1000});
    capture(0, 10, w, ln, cw, ok);
    n_chk++; if ({w[3:0], ok, ln, cw} !== {4'd2, 1'b1, 2'd2, 7'b1110000})
      $display("FAIL mid_post: got wait=%0d ok=%b lane=%0d cw=%b want 2/1/2/1110000", w, ok, ln, cw); else n_pass++;
    stray = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (tx_frame != 4'b0) stray = 1'b1;
    end
    n_chk++; if (stray !== 1'b0) $display("FAIL mid_no_resume: got stray frame=%b want 0", stray); else n_pass++;
  endtask

`ifdef ERR_INJECT_EN
  task automatic test_err();
    int w; logic [1:0] ln; logic [1:7] cw; bit ok;
    err_mask = 7'b0010000;
    push(0, {2'd1, 4'b1011});
    capture(0, 10, w, ln, cw, ok);
    err_mask = '0;
    n_chk++; if ({ok, ln, cw} !== {1'b1, 2'd1, 7'b0100011})
      $display("FAIL err_inject: got ok=%b lane=%0d cw=%b want ok=1 lane=1 cw=0100011", ok, ln, cw); else n_pass++;
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back();
    int w; logic [1:0] ln; logic [1:7] cw; bit ok;
    push(1, {2'd0, 4'b0100});
    push(1, {2'd3, 4'b0110});
    push(1, {2'd1, 4'b0001});
    capture(1, 10, w, ln, cw, ok);
    n_chk++; if ({ok, ln, cw} !== {1'b1, 2'd0, 7'b1001100})
      $display("FAIL b2b_frame1: got ok=%b lane=%0d cw=%b want 1/0/1001100", ok, ln, cw); else n_pass++;
    @(negedge clk);
    capture(1, 10, w, ln, cw, ok);
    n_chk++; if ({w[3:0], ok, ln, cw} !== {4'd0, 1'b1, 2'd3, 7'b1100110})
      $display("FAIL b2b_frame2: got wait=%0d ok=%b lane=%0d cw=%b want 0/1/3/1100110", w, ok, ln, cw); else n_pass++;
    @(negedge clk);
    capture(1, 10, w, ln, cw, ok);
    n_chk++; if ({w[3:0], ok, ln, cw} !== {4'd0, 1'b1, 2'd1, 7'b1101001})
      $display("FAIL b2b_frame3: got wait=%0d ok=%b lane=%0d cw=%b want 0/1/1/1101001", w, ok, ln, cw); else n_pass++;
    @(negedge clk);
    n_chk++; if ({tx_frame0, fifo_count0, busy0, in_ready0} !== 9'b000000001)
      $display("FAIL b2b_end: got frame=%b count=%0d busy=%b rdy=%b want 0000/0/0/1",
               tx_frame0, fifo_count0, busy0, in_ready0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_backpressure();
    test_reset_mid();
`ifdef ERR_INJECT_EN
    test_err();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
